// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost movement scheduler.
package ghost_pkg;
  localparam int DEF_GHOSTS = 4;
  localparam int POS_W      = 10;
  localparam int MAZE_COLS  = 32;

  typedef logic [POS_W-1:0]                  pos_t;
  typedef logic [$clog2(DEF_GHOSTS)-1:0]     ghost_idx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ADVANCE} sched_state_t;
endpackage

// File: rtl/ghost_move_scheduler_idx_select.sv
// Find-next-set-bit: lowest set bit of mask, either anywhere (first) or
// strictly above cur.
module ghost_idx_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] cur,
  input  logic          first,
  output logic [IW-1:0] nxt,
  output logic          valid
);
  // Scan downwards so the lowest qualifying bit is the one left standing.
  always_comb begin
    nxt   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (first || i > int'(cur))) begin
        nxt   = IW'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ghost_move_scheduler.sv
// Time-shares one next-position engine across all ghosts, once per move tick,
// and owns the authoritative ghost position registers.
module ghost_move_scheduler #(
  parameter int NUM_GHOSTS = 4,
  parameter int POS_W      = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        move_tick,
  input  logic [NUM_GHOSTS-1:0]       ghost_en,
  input  logic [NUM_GHOSTS*POS_W-1:0] home_pos,
  input  logic [NUM_GHOSTS*POS_W-1:0] target_pos,
  input  logic                        clr_err,
  output logic                        eng_start,
  output logic [POS_W-1:0]            eng_curr_pos,
  output logic [POS_W-1:0]            eng_target_pos,
  input  logic                        eng_ready,
  input  logic                        eng_done,
  input  logic [POS_W-1:0]            eng_next_pos,
  output logic [NUM_GHOSTS*POS_W-1:0] ghost_pos,
  output logic                        busy,
  output logic                        round_done,
  output logic                        overrun,
  output logic                        timeout_err
);
  import ghost_pkg::*;

  localparam int IW = $clog2(NUM_GHOSTS);
  localparam int CW = $clog2(TIMEOUT);

  sched_state_t                         state;
  logic [NUM_GHOSTS-1:0]                en_q;
  logic [NUM_GHOSTS-1:0][POS_W-1:0]     tgt_q;
  logic [NUM_GHOSTS-1:0][POS_W-1:0]     pos_q;
  logic [IW-1:0]                        idx;
  logic [CW-1:0]                        wcnt;

  logic [NUM_GHOSTS-1:0] sel_mask;
  logic                  sel_first;
  logic [IW-1:0]         sel_idx;
  logic                  sel_valid;

  // At round start the live enable is scanned (it is latched on the same edge);
  // afterwards the snapshot is walked upward from the current ghost.
  assign sel_first = (state == IDLE);
  assign sel_mask  = sel_first ? ghost_en : en_q;

  ghost_idx_select #(.N(NUM_GHOSTS), .IW(IW)) u_sel (
    .mask  (sel_mask),
    .cur   (idx),
    .first (sel_first),
    .nxt   (sel_idx),
    .valid (sel_valid)
  );

  // Request operands stay stable through ISSUE and WAIT: idx and tgt_q are
  // frozen there and pos_q[idx] only changes on the edge leaving WAIT.
  assign eng_curr_pos   = pos_q[idx];
  assign eng_target_pos = tgt_q[idx];
  assign ghost_pos      = pos_q;

  // Round sequencer, position commit and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      en_q        <= '0;
      tgt_q       <= '0;
      idx         <= '0;
      wcnt        <= '0;
      eng_start   <= 1'b0;
      busy        <= 1'b0;
      round_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_GHOSTS; i++) pos_q[i] <= home_pos[i*POS_W +: POS_W];
    end else begin
      eng_start  <= 1'b0;
      round_done <= 1'b0;
      // Clear first so a same-cycle error event overrides it.
      if (clr_err) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (move_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (move_tick) begin
          en_q  <= ghost_en;
          tgt_q <= target_pos;
          if (sel_valid) begin
            idx   <= sel_idx;
            busy  <= 1'b1;
            state <= ISSUE;
          end else begin
            round_done <= 1'b1;
          end
        end
        ISSUE: if (eng_ready) begin
          eng_start <= 1'b1;
          wcnt      <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (eng_done) begin
            pos_q[idx] <= eng_next_pos;
            state      <= ADVANCE;
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= ADVANCE;
          end
        end
        ADVANCE: if (sel_valid) begin
          idx   <= sel_idx;
          state <= ISSUE;
        end else begin
          round_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
